// File: rtl/hub75_dbuf_framebuffer_pkg.sv
// hub75_dbuf_framebuffer_pkg
// Shared definitions for the double-buffered HUB75 framebuffer:
//   - bit positions of R/G/B inside the 3-bit RGB0/RGB1 outputs
//   - the swap controller state encoding
//   - width helpers that turn the geometry parameters into port widths
// No ports; imported by the interface, the RAM and the top module.
package hub75_dbuf_framebuffer_pkg;

   localparam int R_IDX = 2;
   localparam int G_IDX = 1;
   localparam int B_IDX = 0;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } swap_state_t;

   function automatic int calc_cw(input int cols);
      return $clog2(cols);
   endfunction

   function automatic int calc_aw(input int rows_half);
      return $clog2(rows_half);
   endfunction

   // BPC = 1 would give a zero-width plane selector, so clamp to one bit.
   function automatic int calc_pw(input int bpc);
      int w;
      w = $clog2(bpc);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/hub75_dbuf_framebuffer_if.sv
// hub75_dbuf_framebuffer_if
// Bundles every non-clock signal of the framebuffer:
//   read bus  : rd_en, column, ADDR, plane -> RGB0, RGB1, rd_valid
//   write bus : wr_en, wr_x, wr_y, wr_data
//   swap ctrl : swap_req, frame_end -> swap_pending, swap_done, front_page
// master = scan sequencer / pixel source side, slave = framebuffer side.
interface hub75_dbuf_framebuffer_if
   import hub75_dbuf_framebuffer_pkg::*;
#(
   parameter int COLS      = 64,
   parameter int ROWS_HALF = 16,
   parameter int BPC       = 4
);

   localparam int CW = calc_cw(COLS);
   localparam int AW = calc_aw(ROWS_HALF);
   localparam int PW = calc_pw(BPC);

   logic          rd_en;
   logic [CW-1:0] column;
   logic [AW-1:0] ADDR;
   logic [PW-1:0] plane;
   logic [2:0]    RGB0;
   logic [2:0]    RGB1;
   logic          rd_valid;

   logic             wr_en;
   logic [CW-1:0]    wr_x;
   logic [AW:0]      wr_y;
   logic [3*BPC-1:0] wr_data;

   logic swap_req;
   logic frame_end;
   logic swap_pending;
   logic swap_done;
   logic front_page;

   modport master (
      output rd_en, column, ADDR, plane,
      output wr_en, wr_x, wr_y, wr_data,
      output swap_req, frame_end,
      input  RGB0, RGB1, rd_valid,
      input  swap_pending, swap_done, front_page
   );

   modport slave (
      input  rd_en, column, ADDR, plane,
      input  wr_en, wr_x, wr_y, wr_data,
      input  swap_req, frame_end,
      output RGB0, RGB1, rd_valid,
      output swap_pending, swap_done, front_page
   );

endinterface

// File: rtl/hub75_dbuf_framebuffer_fb_dpram.sv
// fb_dpram
// Simple dual-port RAM: one write port, one read port with a registered
// output, written so that synthesis maps it onto block RAM.
// Ports:
//   clk, rst      : clock; rst clears only the read data register
//   we/waddr/wdata: write port, one word per cycle
//   re/raddr      : read port, data appears on rdata after the next edge
//   rdata         : read data register, holds while re is low
module fb_dpram
#(
   parameter int  DEPTH  = 2048,
   parameter int  WIDTH  = 12,
   localparam int ADDR_W = $clog2(DEPTH)
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage array is never reset so it stays a pure block RAM.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Output register only; its reset maps onto the BRAM output-register reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/hub75_dbuf_framebuffer.sv
// hub75_dbuf_framebuffer
// Writable double-buffered framebuffer for the HUB75 panel driver. Two RAMs
// (top and bottom panel half) each hold two pages; the scan sequencer reads
// the front page one bit-plane at a time, the pixel source writes the back
// page, and the pages swap only on a frame boundary.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of hub75_dbuf_framebuffer_if (read bus, write bus,
//          swap request/status)
module hub75_dbuf_framebuffer
   import hub75_dbuf_framebuffer_pkg::*;
#(
   parameter int COLS      = 64,
   parameter int ROWS_HALF = 16,
   parameter int BPC       = 4
)
(
   input  logic                     clk,
   input  logic                     rst,
   hub75_dbuf_framebuffer_if.slave  bus
);

   localparam int CW    = calc_cw(COLS);
   localparam int AW    = calc_aw(ROWS_HALF);
   localparam int PW    = calc_pw(BPC);
   localparam int WW    = 3 * BPC;
   localparam int RAW   = 1 + AW + CW;
   localparam int DEPTH = 2 * ROWS_HALF * COLS;

   swap_state_t state_q, state_d;
   logic        front_page_q;
   logic        swap_done_q;
   logic        toggle;

   logic [PW-1:0]  plane_q;
   logic           rd_valid_q;
   logic           rd_accept;
   logic           top_we;
   logic           bot_we;
   logic [RAW-1:0] wr_addr;
   logic [RAW-1:0] rd_addr;
   logic [WW-1:0]  top_q;
   logic [WW-1:0]  bot_q;

   // Picks one bit-plane out of a {R,G,B} word; planes >= BPC read as black.
   function automatic logic [2:0] pick_plane(input logic [WW-1:0] w,
                                             input logic [PW-1:0] p);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < BPC; i++) begin
         if (p == PW'(i)) begin
            r[R_IDX] = w[2*BPC + i];
            r[G_IDX] = w[BPC + i];
            r[B_IDX] = w[i];
         end
      end
      return r;
   endfunction

   // Reads always hit the front page and writes the back page, so the two
   // ports of a RAM never touch the same word at one edge. Both strobes are
   // masked during reset.
   assign rd_accept = bus.rd_en & ~rst;
   assign rd_addr   = {front_page_q, bus.ADDR, bus.column};
   assign wr_addr   = {~front_page_q, bus.wr_y[AW-1:0], bus.wr_x};
   assign top_we    = bus.wr_en & ~rst & ~bus.wr_y[AW];
   assign bot_we    = bus.wr_en & ~rst &  bus.wr_y[AW];

   fb_dpram #(.DEPTH(DEPTH), .WIDTH(WW)) u_top (
      .clk   (clk),
      .rst   (rst),
      .we    (top_we),
      .waddr (wr_addr),
      .wdata (bus.wr_data),
      .re    (rd_accept),
      .raddr (rd_addr),
      .rdata (top_q)
   );

   fb_dpram #(.DEPTH(DEPTH), .WIDTH(WW)) u_bot (
      .clk   (clk),
      .rst   (rst),
      .we    (bot_we),
      .waddr (wr_addr),
      .wdata (bus.wr_data),
      .re    (rd_accept),
      .raddr (rd_addr),
      .rdata (bot_q)
   );

   // The plane travels with the RAM read so the select lines up with the
   // registered word; both hold while rd_en is low, which keeps RGB stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         plane_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) begin
            plane_q <= bus.plane;
         end
      end
   end

   assign bus.RGB0     = pick_plane(top_q, plane_q);
   assign bus.RGB1     = pick_plane(bot_q, plane_q);
   assign bus.rd_valid = rd_valid_q;

   // Swap controller state, displayed page and the done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         front_page_q <= 1'b0;
         swap_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         front_page_q <= front_page_q ^ toggle;
         swap_done_q  <= toggle;
      end
   end

   // A request coinciding with frame_end swaps immediately; otherwise it
   // waits for the next frame_end. Extra requests while waiting are dropped.
   always_comb begin
      state_d = state_q;
      toggle  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.swap_req) begin
               if (bus.frame_end) begin
                  toggle = 1'b1;
               end else begin
                  state_d = PENDING;
               end
            end
         end
         PENDING: begin
            if (bus.frame_end) begin
               toggle  = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.swap_pending = (state_q == PENDING);
   assign bus.swap_done    = swap_done_q;
   assign bus.front_page   = front_page_q;

endmodule

// File: tb/tb_hub75_dbuf_framebuffer.sv
// tb_hub75_dbuf_framebuffer
// Directed bench for hub75_dbuf_framebuffer. A 64x32, 4-bit instance covers
// writes, swaps, page isolation, corners and streaming reads; a small 3-bit
// instance covers the out-of-range bit-plane. Read expectations are queued
// at issue time and popped by monitors whenever rd_valid is seen.
module tb_hub75_dbuf_framebuffer;

   typedef struct packed {
      logic [2:0] rgb0;
      logic [2:0] rgb1;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   exp_t q_main  [$];
   exp_t q_small [$];
   exp_t e_main;
   exp_t e_small;

   logic [2:0] t0 [4];
   logic [2:0] t1 [4];

   always #5 clk = ~clk;

   hub75_dbuf_framebuffer_if #(.COLS(64), .ROWS_HALF(16), .BPC(4)) bus ();
   hub75_dbuf_framebuffer_if #(.COLS(8),  .ROWS_HALF(2),  .BPC(3)) bus3 ();

   hub75_dbuf_framebuffer #(.COLS(64), .ROWS_HALF(16), .BPC(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   hub75_dbuf_framebuffer #(.COLS(8), .ROWS_HALF(2), .BPC(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int cycles);
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic writePixel(input logic [5:0] x, input logic [4:0] y,
                             input logic [11:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_x    = x;
      bus.wr_y    = y;
      bus.wr_data = d;
      applyStimulus(1);
      bus.wr_en   = 1'b0;
   endtask

   task automatic readPixel(input logic [5:0] col, input logic [3:0] row,
                            input logic [1:0] pl, input logic [2:0] x0,
                            input logic [2:0] x1);
      exp_t v;
      v.rgb0 = x0;
      v.rgb1 = x1;
      q_main.push_back(v);
      bus.rd_en  = 1'b1;
      bus.column = col;
      bus.ADDR   = row;
      bus.plane  = pl;
      applyStimulus(1);
      bus.rd_en  = 1'b0;
   endtask

   task automatic readSmall(input logic [1:0] pl, input logic [2:0] x0,
                            input logic [2:0] x1);
      exp_t v;
      v.rgb0 = x0;
      v.rgb1 = x1;
      q_small.push_back(v);
      bus3.rd_en  = 1'b1;
      bus3.column = 3'd2;
      bus3.ADDR   = 1'b0;
      bus3.plane  = pl;
      applyStimulus(1);
      bus3.rd_en  = 1'b0;
   endtask

   task automatic coincidentSwap();
      bus.swap_req  = 1'b1;
      bus.frame_end = 1'b1;
      applyStimulus(1);
      bus.swap_req  = 1'b0;
      bus.frame_end = 1'b0;
   endtask

   // Monitor for the main instance: every valid read consumes one expectation.
   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1) begin
         if (q_main.size() == 0) begin
            checkOutput("main unexpected rd_valid", 32'd1, 32'd0);
         end else begin
            e_main = q_main.pop_front();
            checkOutput("main RGB0", 32'(bus.RGB0), 32'(e_main.rgb0));
            checkOutput("main RGB1", 32'(bus.RGB1), 32'(e_main.rgb1));
         end
      end
   end

   // Monitor for the 3-bit instance.
   always @(negedge clk) begin
      if (bus3.rd_valid === 1'b1) begin
         if (q_small.size() == 0) begin
            checkOutput("small unexpected rd_valid", 32'd1, 32'd0);
         end else begin
            e_small = q_small.pop_front();
            checkOutput("small RGB0", 32'(bus3.RGB0), 32'(e_small.rgb0));
            checkOutput("small RGB1", 32'(bus3.RGB1), 32'(e_small.rgb1));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus.rd_en = 0;  bus.column = 0;  bus.ADDR = 0;  bus.plane = 0;
      bus.wr_en = 0;  bus.wr_x = 0;    bus.wr_y = 0;  bus.wr_data = 0;
      bus.swap_req = 0;  bus.frame_end = 0;
      bus3.rd_en = 0; bus3.column = 0; bus3.ADDR = 0; bus3.plane = 0;
      bus3.wr_en = 0; bus3.wr_x = 0;   bus3.wr_y = 0; bus3.wr_data = 0;
      bus3.swap_req = 0; bus3.frame_end = 0;

      // Reset state
      applyStimulus(2);
      checkOutput("reset RGB0", 32'(bus.RGB0), 32'd0);
      checkOutput("reset RGB1", 32'(bus.RGB1), 32'd0);
      checkOutput("reset rd_valid", 32'(bus.rd_valid), 32'd0);
      checkOutput("reset front_page", 32'(bus.front_page), 32'd0);
      checkOutput("reset swap_pending", 32'(bus.swap_pending), 32'd0);
      rst = 1'b0;

      // Back page (page 1) gets the two test pixels
      writePixel(6'd5, 5'd3,  12'hA5F);
      writePixel(6'd5, 5'd19, 12'h108);

      // Swap handshake with an ignored second request
      bus.swap_req = 1'b1;
      applyStimulus(1);
      bus.swap_req = 1'b0;
      checkOutput("pending after req", 32'(bus.swap_pending), 32'd1);
      checkOutput("front before frame_end", 32'(bus.front_page), 32'd0);
      applyStimulus(2);
      bus.swap_req = 1'b1;
      applyStimulus(1);
      bus.swap_req = 1'b0;
      checkOutput("pending after 2nd req", 32'(bus.swap_pending), 32'd1);
      checkOutput("front after 2nd req", 32'(bus.front_page), 32'd0);
      checkOutput("no done before swap", 32'(bus.swap_done), 32'd0);
      bus.frame_end = 1'b1;
      applyStimulus(1);
      bus.frame_end = 1'b0;
      checkOutput("front after swap", 32'(bus.front_page), 32'd1);
      checkOutput("pending cleared", 32'(bus.swap_pending), 32'd0);
      checkOutput("swap_done pulse", 32'(bus.swap_done), 32'd1);
      applyStimulus(1);
      checkOutput("swap_done one cycle", 32'(bus.swap_done), 32'd0);
      checkOutput("front stable", 32'(bus.front_page), 32'd1);
      bus.frame_end = 1'b1;
      applyStimulus(1);
      bus.frame_end = 1'b0;
      checkOutput("idle frame_end front", 32'(bus.front_page), 32'd1);
      checkOutput("idle frame_end done", 32'(bus.swap_done), 32'd0);

      // Plane extraction from the freshly displayed page
      readPixel(6'd5, 4'd3, 2'd0, 3'b011, 3'b100);
      readPixel(6'd5, 4'd3, 2'd1, 3'b101, 3'b000);
      readPixel(6'd5, 4'd3, 2'd2, 3'b011, 3'b000);
      readPixel(6'd5, 4'd3, 2'd3, 3'b101, 3'b001);

      // Page isolation: writes land on page 0 while page 1 is shown
      writePixel(6'd5, 5'd3,  12'hFFF);
      writePixel(6'd5, 5'd19, 12'h000);
      readPixel(6'd5, 4'd3, 2'd3, 3'b101, 3'b001);
      coincidentSwap();
      checkOutput("coincident front", 32'(bus.front_page), 32'd0);
      checkOutput("coincident pending", 32'(bus.swap_pending), 32'd0);
      checkOutput("coincident done", 32'(bus.swap_done), 32'd1);
      readPixel(6'd5, 4'd3, 2'd3, 3'b111, 3'b000);

      // Corner pixels on page 1
      writePixel(6'd63, 5'd15, 12'h800);
      writePixel(6'd63, 5'd31, 12'h00C);
      coincidentSwap();
      checkOutput("corner swap front", 32'(bus.front_page), 32'd1);
      readPixel(6'd63, 4'd15, 2'd3, 3'b100, 3'b001);
      readPixel(6'd63, 4'd15, 2'd2, 3'b000, 3'b001);
      readPixel(6'd63, 4'd15, 2'd0, 3'b000, 3'b000);

      // Streaming reads cycling through all planes of pixel (5,3)
      t0[0] = 3'b011; t0[1] = 3'b101; t0[2] = 3'b011; t0[3] = 3'b101;
      t1[0] = 3'b100; t1[1] = 3'b000; t1[2] = 3'b000; t1[3] = 3'b001;
      for (int i = 0; i < 64; i++) begin
         readPixel(6'd5, 4'd3, 2'(i % 4), t0[i % 4], t1[i % 4]);
         checkOutput("stream rd_valid", 32'(bus.rd_valid), 32'd1);
      end
      applyStimulus(1);
      checkOutput("rd_valid drops", 32'(bus.rd_valid), 32'd0);

      // Mid-operation reset discards the request and ignores a write
      bus.swap_req = 1'b1;
      applyStimulus(1);
      bus.swap_req = 1'b0;
      checkOutput("pending before rst", 32'(bus.swap_pending), 32'd1);
      rst         = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_x    = 6'd5;
      bus.wr_y    = 5'd3;
      bus.wr_data = 12'h000;
      applyStimulus(1);
      rst       = 1'b0;
      bus.wr_en = 1'b0;
      checkOutput("rst pending", 32'(bus.swap_pending), 32'd0);
      checkOutput("rst front", 32'(bus.front_page), 32'd0);
      checkOutput("rst rd_valid", 32'(bus.rd_valid), 32'd0);
      checkOutput("rst RGB0", 32'(bus.RGB0), 32'd0);
      bus.frame_end = 1'b1;
      applyStimulus(1);
      bus.frame_end = 1'b0;
      checkOutput("post-rst frame_end front", 32'(bus.front_page), 32'd0);
      checkOutput("post-rst frame_end done", 32'(bus.swap_done), 32'd0);
      readPixel(6'd5, 4'd3, 2'd3, 3'b111, 3'b000);

      // 3-bit instance: plane 3 is out of range
      bus3.wr_en   = 1'b1;
      bus3.wr_x    = 3'd2;
      bus3.wr_y    = 2'b00;
      bus3.wr_data = 9'b100_010_001;
      applyStimulus(1);
      bus3.wr_y    = 2'b10;
      bus3.wr_data = 9'b111_111_111;
      applyStimulus(1);
      bus3.wr_en     = 1'b0;
      bus3.swap_req  = 1'b1;
      bus3.frame_end = 1'b1;
      applyStimulus(1);
      bus3.swap_req  = 1'b0;
      bus3.frame_end = 1'b0;
      checkOutput("small front", 32'(bus3.front_page), 32'd1);
      readSmall(2'd0, 3'b001, 3'b111);
      readSmall(2'd1, 3'b010, 3'b111);
      readSmall(2'd2, 3'b100, 3'b111);
      readSmall(2'd3, 3'b000, 3'b000);

      applyStimulus(3);
      checkOutput("main queue drained", 32'(q_main.size()), 32'd0);
      checkOutput("small queue drained", 32'(q_small.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hub75_dbuf_framebuffer.md
# hub75_dbuf_framebuffer

Parametrised, writable, double-buffered framebuffer for the HUB75 panel driver. It replaces the fixed 64×32, 1-bit-per-channel ROM image with two RAM pages, each holding COLS × 2·ROWS_HALF pixels at BPC bits per channel. The scan/BCM sequencer reads the front page one bit-plane at a time for the upper and lower panel halves simultaneously. A pixel source writes the back page, and the two pages swap only at a frame boundary.

## Interface
- COLS, 64, pixels per row; power of two; CW = clog2(COLS)
- ROWS_HALF, 16, rows per panel half (scan lines); power of two; AW = clog2(ROWS_HALF)
- BPC, 4, bits per colour channel, 1..8; PW = max(1, clog2(BPC))
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rd_en  in  1  read strobe from the scan sequencer
- column  in  CW  pixel column to read
- ADDR  in  AW  scan row (same row index in both halves)
- plane  in  PW  bit-plane to extract (0 = LSB)
- RGB0  out  3  upper-half pixel bit {R,G,B} of the selected plane
- RGB1  out  3  lower-half pixel bit {R,G,B}
- rd_valid  out  1  RGB0/RGB1 hold the result of the previous rd_en
- wr_en  in  1  write strobe, back page
- wr_x  in  CW  write column
- wr_y  in  AW+1  write row over the full panel; MSB = 1 selects the lower half
- wr_data  in  3·BPC  {R[BPC-1:0], G, B}
- swap_req  in  1  one-cycle request to exchange pages
- frame_end  in  1  one-cycle pulse from the sequencer at the end of a full frame
- swap_pending  out  1  request accepted, swap not yet performed
- swap_done  out  1  one-cycle pulse in the cycle after the swap edge
- front_page  out  1  page currently displayed

## Operation
- Storage is two RAMs: top and bottom. Each holds 2 pages × ROWS_HALF × COLS words of 3·BPC bits. The word address is {page, row, column}.
- Write path:
  - wr_en writes wr_data to the RAM selected by wr_y[AW].
  - The target address is {~front_page, wr_y[AW-1:0], wr_x}.
  - Writes never target the front page.
  - Every in-range coordinate is accepted, with no backpressure.
- Read path:
  - rd_en reads both RAMs at {front_page, ADDR, column}.
  - The plane value is registered alongside the address.
  - Output bits are RGB0 = {R[plane], G[plane], B[plane]} of the top word; RGB1 is the same for the bottom word.
  - A plane value ≥ BPC yields 3'b000.
- RGB0/RGB1 hold their last value while rd_en is low; rd_valid follows rd_en, delayed one cycle.
- Swap control is a two-state machine, IDLE and PENDING:
  - IDLE: swap_req without frame_end → PENDING.
  - IDLE: swap_req and frame_end in the same cycle → front_page toggles at that edge and the state stays IDLE.
  - PENDING: frame_end → front_page toggles and the state returns to IDLE.
  - swap_req while PENDING is ignored; requests do not queue.
  - frame_end alone in IDLE has no effect.
  - swap_pending = (state == PENDING).
- Reset (rst = 1 at an edge):
  - Reset values: front_page = 0, state IDLE, swap_pending = 0, swap_done = 0, rd_valid = 0, RGB0 = RGB1 = 0.
  - RAM contents are not cleared.
  - A reset during PENDING discards the request.
  - wr_en and rd_en are ignored in the reset cycle.

## Timing
- Read latency is 1 cycle: rd_en sampled at edge n → RGB0, RGB1 and rd_valid valid after edge n+1.
- Fully pipelined: one read per cycle, back-to-back.
- Write latency is 1 cycle. A write at edge n is readable from edge n+1 once its page is the front page.
- At the swap edge:
  - A read issued in that cycle uses the old front page.
  - A write issued in that cycle goes to the old back page, i.e. the new front page.
  - From the next cycle, reads use the new page and writes go to the old page.
- A read and a write never address the same page at the same edge, so there is no RAM collision case.
- swap_done is high for exactly one cycle, at edge n+1 after the toggle at edge n.

## Structure
- The shared package holds:
  - RGB bit-index constants (R = 2, G = 1, B = 0);
  - the swap state enum {IDLE, PENDING};
  - width helper functions for CW, AW and PW.
- Sub-module fb_dpram: simple dual-port RAM (one write port, one registered read port) with parameters DEPTH and WIDTH, inferred as block RAM. The framebuffer instantiates it twice, as top and bottom.
- Plane select, swap FSM and output registers live in the top module.

## Test plan
- **Reset:** rst high for 2 cycles → RGB0 = RGB1 = 0, rd_valid = 0, front_page = 0, swap_pending = 0.
- **Write/swap/read:** write (x = 5, y = 3, {R=4'hA, G=4'h5, B=4'hF}) and (x = 5, y = 19, {4'h1, 4'h0, 4'h8}). Then swap_req, then frame_end. Then read column 5, ADDR 3:
  - plane 0 → RGB0 = 3'b011, RGB1 = 3'b100;
  - plane 1 → RGB0 = 3'b101, RGB1 = 3'b000;
  - each result one cycle after rd_en.
- **Page isolation:** after the swap, write 4'hF to all channels at (5, 3), then read (5, 3) plane 3 → RGB0 = 3'b101 (old data). After a second swap → 3'b111.
- **Swap handshake:**
  - swap_req → swap_pending = 1. A second swap_req 3 cycles later is ignored. frame_end → exactly one toggle, swap_done pulses once.
  - swap_req coincident with frame_end → toggle at the same edge, swap_pending never asserted.
- **Boundaries:**
  - plane = BPC (BPC = 4, PW = 2 is not reachable, so run with BPC = 3) → output 3'b000.
  - Reads at column COLS−1, ADDR ROWS_HALF−1 → correct corner pixels.
  - 64 back-to-back reads → rd_valid continuously high.
- **Mid-operation reset:** swap_req, then rst before frame_end → swap_pending = 0, front_page = 0, and no toggle on a later frame_end.
